rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel (1..64).
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..32, non-power-of-2 allowed).
REQ-003 SHALL have parameter SEL_W, default 2, channel index width, with SEL_W = clog2(NCH).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port IN_DATA  input  NCH*WIDTH  packed channel data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 SHALL have port IN_VALID  input  NCH  per-channel valid.
REQ-008 SHALL have port IN_READY  output  NCH  per-channel ready, combinational.
REQ-009 SHALL have port MODE  input  1  0 = round-robin, 1 = static select.
REQ-010 SHALL have port SEL  input  SEL_W  channel index used in static mode.
REQ-011 SHALL have port OUT_DATA  output  WIDTH  registered data.
REQ-012 SHALL have port OUT_SEL  output  SEL_W  registered index of the source channel.
REQ-013 SHALL have port OUT_VALID  output  1  registered valid.
REQ-014 SHALL have port OUT_READY  input  1  downstream ready.

Function
REQ-015 SHALL hold a one-entry output register: OUT_DATA, OUT_SEL, OUT_VALID.
REQ-016 SHALL define load = !OUT_VALID || OUT_READY; arbitration SHALL grant only when load=1.
REQ-017 In round-robin mode, SHALL grant the first channel with IN_VALID=1, searching from pointer PTR upward with wrap from NCH-1 to 0.
REQ-018 In static mode, SHALL grant channel SEL only if IN_VALID[SEL]=1; all other channels SHALL stay stalled.
REQ-019 In static mode with SEL >= NCH, SHALL grant no channel.
REQ-020 SHALL drive IN_READY[c]=1 only for the granted channel c; at most one IN_READY bit SHALL be high per cycle.
REQ-021 A transfer occurs when IN_VALID[c] and IN_READY[c] are both 1; on the next edge SHALL set OUT_DATA = channel c data, OUT_SEL = c, OUT_VALID = 1 (latency 1 cycle).
REQ-022 On a round-robin transfer from channel c, SHALL update PTR to (c+1) mod NCH; static-mode transfers SHALL leave PTR unchanged.
REQ-023 If load=1 and no grant is made, SHALL clear OUT_VALID when OUT_READY=1 and leave OUT_DATA/OUT_SEL unchanged.
REQ-024 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_SEL SHALL remain stable and all IN_READY bits SHALL be 0.
REQ-025 A simultaneous drain and load in the same cycle SHALL sustain 1 transfer per cycle with no bubble.
REQ-026 A MODE or SEL change SHALL affect only the current cycle's combinational grant; the registered output SHALL be unaffected.

Reset
REQ-027 While RST=0, SHALL asynchronously force OUT_VALID=0, OUT_DATA=0, OUT_SEL=0 and PTR=0.
REQ-028 While RST=0, all IN_READY bits SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held entry.
REQ-030 After RST deasserts, the first round-robin search SHALL start at channel 0.

Configuration
REQ-031 Macro RR_ARB_MUX_STAT_EN, when defined, SHALL add output GRANT_CNT [15:0].
REQ-032 GRANT_CNT SHALL increment on every transfer, wrap from 0xFFFF to 0, and reset to 0.
REQ-033 When RR_ARB_MUX_STAT_EN is undefined, the GRANT_CNT port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Scenario: reset, then release with all IN_VALID=0 -> OUT_VALID=0, OUT_DATA=0, IN_READY=0.
REQ-035 Scenario: NCH=4, MODE=0, all valid, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-036 Scenario: MODE=1, SEL=2, IN_DATA[2]=0xDEADBEEF valid, channel 0 valid -> OUT_DATA=0xDEADBEEF with OUT_SEL=2 one cycle later; IN_READY[0] stays 0.
REQ-037 Scenario: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_DATA stable and IN_READY=0 throughout; transfer resumes the cycle OUT_READY=1.
REQ-038 Scenario: NCH=3, PTR=2, only channel 0 valid -> channel 0 granted, PTR becomes 1.
REQ-039 Scenario: RST pulsed low while OUT_VALID=1, with RR_ARB_MUX_STAT_EN defined and GRANT_CNT=5 -> OUT_VALID=0 and GRANT_CNT=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: channel-side and output-side bundle for rr_arb_mux.
// slave = arbiter side, master = traffic source / sink side.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NCH-way round-robin / static-select arbiter into a
// one-entry registered output (OUT_DATA/OUT_SEL/OUT_VALID).
// Ports: clk, rst_n (async, active low), bus (rr_arb_mux_if.slave):
//   in_data/in_valid/in_ready per channel, mode (0 rr, 1 static),
//   sel, out_data/out_sel/out_valid/out_ready.
// Option: RR_ARB_MUX_STAT_EN adds grant_cnt[15:0] transfer counter.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arb_mux_if.slave  bus
`ifdef RR_ARB_MUX_STAT_EN
  ,
  output logic [15:0]  grant_cnt
`endif
);

  localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NCH - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   cand;
  logic             rr_hit;
  logic             st_hit;
  logic             load;
  logic             gnt;
  logic [WIDTH-1:0] gnt_data;

  // Rotating search from ptr; the extra bit keeps ptr+i from
  // overflowing before the modulo fold.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= NCH_W)
        cand = cand - NCH_W;
      if (!rr_hit && bus.in_valid[cand[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = cand[SEL_W-1:0];
      end
    end
  end

  // Compare against each real channel so sel >= NCH never hits.
  always_comb begin
    st_hit = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.sel == SEL_W'(c) && bus.in_valid[c])
        st_hit = 1'b1;
    end
  end

  assign load    = !bus.out_valid || bus.out_ready;
  assign gnt_idx = bus.mode ? bus.sel : rr_idx;
  assign gnt     = rst_n && load && (bus.mode ? st_hit : rr_hit);
  assign ptr_nxt = (rr_idx == LAST) ? '0 : rr_idx + SEL_W'(1);

  always_comb begin
    bus.in_ready = '0;
    gnt_data     = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_idx == SEL_W'(c)) begin
        bus.in_ready[c] = gnt;
        gnt_data        = bus.in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
      ptr           <= '0;
    end else if (load) begin
      if (gnt) begin
        bus.out_data  <= gnt_data;
        bus.out_sel   <= gnt_idx;
        bus.out_valid <= 1'b1;
        if (!bus.mode)
          ptr <= ptr_nxt;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_MUX_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_cnt <= '0;
    else if (gnt)
      grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: scoreboard bench for rr_arb_mux (4-ch main DUT,
// plus a 3-ch instance for wrap and out-of-range select cases).
module tb_rr_arb_mux;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int W3 = 8;
  localparam int N3 = 3;

  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   mptr;
  int   mcnt;
  bit   exp_vld;
  bit   mon_en;
  exp_t q[$];
  logic [15:0] gcnt;
  logic [15:0] gcnt3;

  rr_arb_mux_if #(.WIDTH(W), .NCH(N), .SEL_W(S)) bus();
  rr_arb_mux_if #(.WIDTH(W3), .NCH(N3), .SEL_W(S)) bus3();

  rr_arb_mux #(.WIDTH(W), .NCH(N), .SEL_W(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef RR_ARB_MUX_STAT_EN
    ,
    .grant_cnt(gcnt)
`endif
  );

  rr_arb_mux #(.WIDTH(W3), .NCH(N3), .SEL_W(S)) dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus3)
`ifdef RR_ARB_MUX_STAT_EN
    ,
    .grant_cnt(gcnt3)
`endif
  );

`ifndef RR_ARB_MUX_STAT_EN
  assign gcnt  = '0;
  assign gcnt3 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rd();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++)
      r[k*W +: W] = $urandom;
    return r;
  endfunction

  // Reference: output register modelled as the head of q.
  task automatic drive(input logic [N-1:0] v, input logic m,
                       input logic [S-1:0] s, input logic ordy,
                       input logic [N*W-1:0] d);
    int g;
    logic [N-1:0] er;
    logic ld;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.sel       = s;
    bus.out_ready = ordy;
    bus.in_data   = d;
    #1;
    exp_vld = (q.size() != 0);
    ld = !exp_vld || ordy;
    g = -1;
    if (ld) begin
      if (m) begin
        if (int'(s) < N && v[s]) g = int'(s);
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mptr + k) % N;
          if (g < 0 && v[c]) g = c;
        end
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(er));
`ifdef RR_ARB_MUX_STAT_EN
    chk("grant_cnt", 64'(gcnt), 64'(mcnt[15:0]));
`endif
    if (g >= 0) begin
      e.d = d[g*W +: W];
      e.s = S'(g);
      q.push_back(e);
      mcnt++;
      if (!m) mptr = (g + 1) % N;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        if (bus.out_valid && q.size() > 0) begin
          chk("out_data", 64'(bus.out_data), 64'(q[0].d));
          chk("out_sel", 64'(bus.out_sel), 64'(q[0].s));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  logic [2:0] v3[6] = '{3'b010, 3'b001, 3'b111, 3'b111, 3'b111, 3'b111};
  logic       m3[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] s3[6] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
  int         g3[6] = '{1, 0, 1, -1, 0, 2};

  initial begin
    logic [N*W-1:0] d;
    logic [N3*W3-1:0] d3;
    logic [W3-1:0] last3;
    logic [2:0] e3;
    int lastg;
    n_cmp = 0; n_bad = 0; mptr = 0; mcnt = 0;
    exp_vld = 1'b0; mon_en = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = '1; bus.in_data = rd(); bus.mode = 1'b0;
    bus.sel = '0; bus.out_ready = 1'b1;
    bus3.in_valid = '1; bus3.in_data = '1; bus3.mode = 1'b0;
    bus3.sel = '0; bus3.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_in_ready3", 64'(bus3.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_sel", 64'(bus.out_sel), 64'd0);
    chk("rst_gcnt", 64'(gcnt), 64'd0);
    @(negedge clk);
    bus.in_valid = '0;
    bus3.in_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_out_data", 64'(bus.out_data), 64'd0);

    lastg = -1;
    last3 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < N3; k++) d3[k*W3 +: W3] = W3'($urandom);
      bus3.in_valid = v3[i];
      bus3.mode     = m3[i];
      bus3.sel      = s3[i];
      bus3.in_data  = d3;
      #1;
      e3 = '0;
      if (g3[i] >= 0) e3[g3[i]] = 1'b1;
      chk("n3_in_ready", 64'(bus3.in_ready), 64'(e3));
      chk("n3_out_valid", 64'(bus3.out_valid), 64'(lastg >= 0));
      if (lastg >= 0) begin
        chk("n3_out_sel", 64'(bus3.out_sel), 64'(lastg));
        chk("n3_out_data", 64'(bus3.out_data), 64'(last3));
      end
      if (g3[i] >= 0) last3 = d3[g3[i]*W3 +: W3];
      lastg = g3[i];
    end
    @(negedge clk);
    bus3.in_valid = '0;

    mon_en = 1'b1;
    repeat (5) drive('1, 1'b0, '0, 1'b1, rd());
    d = rd();
    d[2*W +: W] = 32'hDEADBEEF;
    drive(4'b0101, 1'b1, 2'd2, 1'b1, d);
    drive(4'b0000, 1'b0, '0, 1'b1, rd());
    drive('1, 1'b0, '0, 1'b1, rd());
    repeat (3) drive('1, 1'b0, '0, 1'b0, rd());
    drive('1, 1'b0, '0, 1'b1, rd());
    repeat (400)
      drive(N'($urandom), ($urandom_range(0, 3) == 0), S'($urandom),
            ($urandom_range(0, 9) < 7), rd());

    drive('1, 1'b0, '0, 1'b0, rd());
    drive('1, 1'b0, '0, 1'b0, rd());
    @(negedge clk);
    bus.in_valid = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_out_sel", 64'(bus.out_sel), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_gcnt", 64'(gcnt), 64'd0);
    mon_en = 1'b0;
    q.delete();
    mptr = 0;
    mcnt = 0;
    exp_vld = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) drive('1, 1'b0, '0, 1'b1, rd());
    repeat (100)
      drive(N'($urandom), ($urandom_range(0, 3) == 0), S'($urandom),
            ($urandom_range(0, 9) < 7), rd());
    repeat (3) drive('0, 1'b0, '0, 1'b1, rd());
    chk("drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
